// File: rtl/merge_pkg.sv
// Shared definitions for the merge tree: tuple geometry, word type and the
// run-terminator test used by the merger control and later merge levels.
package merge_pkg;

   localparam int unsigned P              = 16;   // tuples per word
   localparam int unsigned DEF_DATA_WIDTH = 128;  // bits per tuple
   localparam int unsigned DEF_KEY_WIDTH  = 80;   // key bits, LSB-aligned in a tuple

   typedef logic [DEF_DATA_WIDTH-1:0]   tuple_t;
   typedef logic [P*DEF_DATA_WIDTH-1:0] word_t;

   // A word terminates a run when its lowest tuple is all-zero.
   function automatic logic is_terminator(input word_t word);
      return ~|word[DEF_DATA_WIDTH-1:0];
   endfunction

endpackage

// File: rtl/sync_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// A push while full is dropped unless a pop happens in the same cycle.
module sync_fwft_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   assign count = count_q;

   // Pop only when data is present; a full FIFO still takes a push if it pops too.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // Head is forced to zero when empty so stale storage never leaks out.
   assign rdata = empty ? '0 : mem[rd_ptr_q];

   // Occupancy next-state.
   always_comb begin
      count_d = count_q;
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointers and count; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end

   // Storage write; contents need no reset since the head is gated by empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/merge_out_buffer.sv
// Output buffer behind the 16-wide merger: tags run terminators on enqueue,
// throttles the merger with slack for its registered ready, drains over
// valid/ready and counts completed runs.
module merge_out_buffer
   import merge_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned KEY_WIDTH  = DEF_KEY_WIDTH,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned SLACK      = 2
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_write,
   input  logic [P*DATA_WIDTH-1:0] i_data,
   output logic                    o_ready,
   output logic [P*DATA_WIDTH-1:0] o_data,
   output logic                    o_last,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic [31:0]             o_run_count,
   output logic                    o_overflow
);

   localparam int unsigned WW = P * DATA_WIDTH;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("DEPTH must be a power of two and at least 4");
   end
   if (SLACK >= DEPTH) begin : g_bad_slack
      $error("SLACK must be less than DEPTH");
   end
   if (KEY_WIDTH > DATA_WIDTH) begin : g_bad_key
      $error("KEY_WIDTH must not exceed DATA_WIDTH");
   end

   logic          in_tag;
   logic [WW:0]   fifo_rdata;
   logic [CW-1:0] fifo_count;
   logic [CW-1:0] free_slots;
   logic          fifo_empty, fifo_full;
   logic          deq;
   logic [31:0]   run_count_q;
   logic          overflow_q;

   // Same test as is_terminator, written against this instance's tuple width.
   assign in_tag = ~|i_data[DATA_WIDTH-1:0];

   sync_fwft_fifo #(
      .WIDTH (WW + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .push  (i_write),
      .wdata ({in_tag, i_data}),
      .pop   (i_ready),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign o_valid = ~fifo_empty;
   assign o_data  = fifo_rdata[WW-1:0];
   assign o_last  = fifo_rdata[WW];
   assign deq     = o_valid & i_ready;

   // Hold back SLACK entries for writes already in flight in the merger.
   assign free_slots = CW'(DEPTH) - fifo_count;
   assign o_ready    = free_slots > CW'(SLACK);

   assign o_run_count = run_count_q;
   assign o_overflow  = overflow_q;

   // Run counter and sticky overflow flag.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         run_count_q <= '0;
         overflow_q  <= 1'b0;
      end else begin
         if (deq && o_last) run_count_q <= run_count_q + 32'd1;
         if (i_write && fifo_full && !deq) overflow_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_merge_out_buffer.sv
// Directed bench for merge_out_buffer: vector table plus multi-cycle sequences.
module tb_merge_out_buffer;

   localparam int DW = 128;
   localparam int NW = 16 * DW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr = 1'b0;
   logic          rdy = 1'b0;
   logic [NW-1:0] din = '0;
   logic          o_ready, o_last, o_valid, o_overflow;
   logic [NW-1:0] o_data;
   logic [31:0]   o_run_count;

   int n_cmp = 0;
   int n_bad = 0;

   merge_out_buffer #(
      .DATA_WIDTH (DW),
      .KEY_WIDTH  (80),
      .DEPTH      (16),
      .SLACK      (2)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_write     (wr),
      .i_data      (din),
      .o_ready     (o_ready),
      .o_data      (o_data),
      .o_last      (o_last),
      .o_valid     (o_valid),
      .i_ready     (rdy),
      .o_run_count (o_run_count),
      .o_overflow  (o_overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          wr;
      logic          rdy;
      logic [NW-1:0] din;
      logic          e_valid;
      logic          e_ready;
      logic          e_last;
      logic          e_ovf;
      logic [NW-1:0] e_head;
   } vec_t;

   vec_t vecs[$];

   // Tuple 0 carries the tag (zero for a terminator); other tuples are nonzero.
   function automatic logic [NW-1:0] mk(input int tag, input bit term);
      logic [NW-1:0] w;
      for (int i = 1; i < 16; i++) w[i*DW +: DW] = {64'(tag), 64'(i)};
      w[DW-1:0] = term ? '0 : 128'(tag);
      return w;
   endfunction

   function automatic void add(input logic w, input logic r, input logic [NW-1:0] d,
                               input logic ev, input logic er, input logic el,
                               input logic eo, input logic [NW-1:0] eh);
      vec_t v;
      v.wr = w; v.rdy = r; v.din = d;
      v.e_valid = ev; v.e_ready = er; v.e_last = el; v.e_ovf = eo; v.e_head = eh;
      vecs.push_back(v);
   endfunction

   task automatic chk_bit(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   task automatic chk_32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_word(input string name, input logic [NW-1:0] act,
                           input logic [NW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got low64 %h expected low64 %h", name, act[63:0], exp[63:0]);
      end
   endtask

   logic [NW-1:0] src[$];
   logic          src_last[$];
   logic [NW-1:0] mq[$];
   logic          ml[$];
   int            idx, exp_runs, lasts_seen, cyc;

   initial begin
      // Vector table: straddles count 1 simultaneity, fill, overflow and drain.
      add(1, 0, mk(5, 0), 1, 1, 0, 0, mk(5, 0));
      add(1, 1, mk(6, 0), 1, 1, 0, 0, mk(6, 0));
      add(0, 1, '0,       0, 1, 0, 0, '0);
      add(0, 1, '0,       0, 1, 0, 0, '0);
      for (int k = 1; k <= 16; k++)
         add(1, 0, mk(100 + k, 0), 1, (k <= 13), 0, 0, mk(101, 0));
      add(1, 0, mk(200, 0), 1, 0, 0, 1, mk(101, 0));
      add(1, 1, mk(201, 0), 1, 0, 0, 1, mk(102, 0));
      for (int j = 1; j <= 16; j++)
         add(0, 1, '0, (j < 16), (j > 2), 0, 1,
             (j <= 14) ? mk(102 + j, 0) : ((j == 15) ? mk(201, 0) : '0));

      // Reset state, checked while reset is held.
      #12;
      chk_bit("reset valid", o_valid, 1'b0);
      chk_bit("reset ready", o_ready, 1'b1);
      chk_bit("reset last", o_last, 1'b0);
      chk_bit("reset overflow", o_overflow, 1'b0);
      chk_32("reset run_count", o_run_count, 32'd0);
      chk_word("reset data", o_data, '0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         wr = vecs[i].wr; rdy = vecs[i].rdy; din = vecs[i].din;
         @(posedge clk); #1;
         chk_bit($sformatf("vec%0d valid", i), o_valid, vecs[i].e_valid);
         chk_bit($sformatf("vec%0d ready", i), o_ready, vecs[i].e_ready);
         chk_bit($sformatf("vec%0d last", i), o_last, vecs[i].e_last);
         chk_bit($sformatf("vec%0d overflow", i), o_overflow, vecs[i].e_ovf);
         chk_word($sformatf("vec%0d head", i), o_data, vecs[i].e_head);
      end
      wr = 1'b0; rdy = 1'b0;

      // Three runs of 4 data words plus a terminator, random drain.
      for (int r = 0; r < 3; r++) begin
         for (int d = 0; d < 4; d++) begin
            src.push_back(mk(300 + r * 10 + d, 0));
            src_last.push_back(1'b0);
         end
         src.push_back(mk(300 + r * 10 + 9, 1));
         src_last.push_back(1'b1);
      end
      idx = 0; exp_runs = 0; lasts_seen = 0; cyc = 0;
      while ((idx < 15 || mq.size() > 0) && cyc < 600) begin
         wr  = (idx < 15) && o_ready;
         din = wr ? src[idx] : '0;
         rdy = 1'($urandom_range(0, 1));
         chk_bit("run valid", o_valid, mq.size() != 0);
         if (o_valid && rdy && mq.size() > 0) begin
            chk_word("run order", o_data, mq[0]);
            chk_bit("run last", o_last, ml[0]);
            if (ml[0]) begin
               exp_runs++;
               lasts_seen++;
            end
            void'(mq.pop_front());
            void'(ml.pop_front());
         end
         if (wr) begin
            mq.push_back(src[idx]);
            ml.push_back(src_last[idx]);
            idx++;
         end
         @(posedge clk); #1;
         chk_32("run count step", o_run_count, 32'(exp_runs));
         cyc++;
      end
      wr = 1'b0; rdy = 1'b0;
      n_cmp++;
      if (cyc >= 600) begin
         n_bad++;
         $display("FAIL run timeout: got %0d cycles expected under 600", cyc);
      end
      chk_32("run total", o_run_count, 32'd3);
      chk_32("terminators seen", 32'(lasts_seen), 32'd3);

      // Seven words queued, then asynchronous reset between edges.
      for (int k = 0; k < 7; k++) begin
         wr = 1'b1; din = mk(400 + k, (k == 3));
         @(posedge clk); #1;
      end
      wr = 1'b0;
      chk_bit("pre-reset valid", o_valid, 1'b1);
      chk_bit("pre-reset ready", o_ready, 1'b1);
      chk_32("pre-reset run_count", o_run_count, 32'd3);
      #2 rst_n = 1'b0;
      #1;
      chk_bit("async reset valid", o_valid, 1'b0);
      chk_bit("async reset ready", o_ready, 1'b1);
      chk_32("async reset run_count", o_run_count, 32'd0);
      chk_word("async reset data", o_data, '0);
      @(negedge clk);
      rst_n = 1'b1;
      wr = 1'b1; din = mk(500, 0);
      @(posedge clk); #1;
      wr = 1'b0;
      chk_word("post-reset head", o_data, mk(500, 0));
      chk_bit("post-reset valid", o_valid, 1'b1);
      chk_bit("post-reset overflow", o_overflow, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/merge_out_buffer.md
# merge_out_buffer

Output buffer directly downstream of the 16-wide merger. It absorbs the merger's write strobe and 16-tuple words into a local FIFO. Its `o_ready` back-pressure carries enough slack to cover the merger's registered-ready latency. It drains to the next stage (next merge level or memory writer) over a valid/ready stream. It also tags run terminators and counts completed runs.

## Interface
Parameters:
- `DATA_WIDTH`, 128: bits per tuple.
- `KEY_WIDTH`, 80: key bits, LSB-aligned within a tuple.
- `DEPTH`, 16: FIFO entries (16-tuple words); must be a power of two, ≥ 4.
- `SLACK`, 2: entries held in reserve after `o_ready` drops; must be < DEPTH.

Ports:
- `i_clk`  in  1  clock; everything is on its rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_write`  in  1  merger output-write strobe; `i_data` is valid this cycle.
- `i_data`  in  16*DATA_WIDTH  merged 16-tuple word.
- `o_ready`  out  1  merger may issue writes (the merger registers this internally).
- `o_data`  out  16*DATA_WIDTH  head word (first-word fall-through).
- `o_last`  out  1  head word is a run terminator.
- `o_valid`  out  1  FIFO non-empty.
- `i_ready`  in  1  consumer accepts head when `o_valid & i_ready`.
- `o_run_count`  out  32  number of terminators dequeued, wraps modulo 2^32.
- `o_overflow`  out  1  sticky: a write arrived while the FIFO was full.

## Operation
- Terminator: a word whose lowest tuple (bits DATA_WIDTH-1:0) is all-zero. The tag is computed on enqueue and stored as a side bit per entry; it is presented as `o_last`.
- Enqueue when `i_write`.
- Dequeue when `o_valid & i_ready`.
- Enqueue and dequeue in the same cycle leave the count unchanged.
- Write while full, with no dequeue that cycle: the word is dropped, `o_overflow` is set, and pointers and count are unchanged.
- Write while full with a simultaneous dequeue is accepted. It is not an overflow.
- `o_ready` = (DEPTH − count) > SLACK, decoded combinationally from the registered count.
- `o_run_count` increments on each dequeue with `o_last` = 1.
- `o_overflow` clears only on reset.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.

## Timing
- Reset values: count 0, pointers 0, `o_valid` 0, `o_last` 0, `o_ready` 1, `o_run_count` 0, `o_overflow` 0, `o_data` 0.
- Reset asserted mid-operation empties the FIFO immediately. Stored contents are treated as lost.
- Latency: a word written at edge N appears on `o_data`/`o_valid` after edge N (visible in cycle N+1) when the FIFO was empty. This is 1-cycle fall-through.
- `o_ready` reflects the count as of the current cycle. The merger can still write up to SLACK words after `o_ready` falls, one from its ready register and one from its output stage. The default of 2 therefore guarantees no overflow with a compliant upstream.
- The head word stays stable while `o_valid & ~i_ready`.
- Dequeue is not permitted when `o_valid` = 0; `i_ready` is ignored in that case.
- `o_run_count` updates on the edge that dequeues the terminator.

## Structure
- Shared package `merge_pkg`:
  - `P` = 16, tuples per word.
  - Default `DATA_WIDTH` / `KEY_WIDTH`.
  - The 16-tuple word typedef.
  - Function `is_terminator(word)`, reused by the merger's control and any later merge level.
- Sub-module `sync_fwft_fifo`:
  - Parameterised width and depth; here the width is 16*DATA_WIDTH+1.
  - Provides count, empty, full and the overflow-drop rule.
  - The top level adds the terminator tagging, the `o_ready` threshold and the run counter.

## Test plan
- Reset, then single write of a word with key 5 in tuple 0 → `o_valid`=1 next cycle, `o_data` equals the input, `o_last`=0, `o_ready`=1.
- Write 14 words, `i_ready`=0, DEPTH=16, SLACK=2 → `o_ready` falls when count reaches 14. Two further writes are accepted: count 16, `o_overflow`=0.
- With FIFO full, a 17th write and no dequeue → word dropped, `o_overflow`=1 and stays 1. The same write with `i_ready`=1 is accepted and count stays 16.
- Stream of 3 runs, each 4 data words plus an all-zero terminator, drained with random `i_ready` → output order preserved. `o_last` is high only on the 3 terminators. `o_run_count`=3.
- Simultaneous write and read at count 1 → count stays 1 and the head advances to the new word on the next cycle.
- Pull `i_rst_n` low mid-stream with count 7 → `o_valid`=0, `o_ready`=1 and `o_run_count`=0 immediately, without waiting for a clock edge.
